// File: rtl/robo_mission_sequencer_if.sv
// Mission sequencer bus: top-level config, Robo activity inputs and the mission status outputs.
interface robo_mission_sequencer_if;
  logic       start;
  logic [7:0] max_moves;
  logic [3:0] start_row;
  logic [3:0] start_col;
  logic [1:0] start_dir;
  logic       advance;
  logic       turn;
  logic       collect;
  logic       robo_enable;
  logic [3:0] row;
  logic [3:0] col;
  logic [1:0] dir;
  logic [7:0] moves;
  logic [3:0] items;
  logic       unloading;
  logic       done;
  logic       fault;
  logic       proto_err;

  modport slave (
    input  start, max_moves, start_row, start_col, start_dir, advance, turn, collect,
    output robo_enable, row, col, dir, moves, items, unloading, done, fault, proto_err
  );

  modport master (
    output start, max_moves, start_row, start_col, start_dir, advance, turn, collect,
    input  robo_enable, row, col, dir, moves, items, unloading, done, fault, proto_err
  );
endinterface

// File: rtl/robo_mission_sequencer.sv
// Mission controller around the collector robot: gates it, tracks pose, move budget,
// bin fill and forced unload pauses; out-of-grid advances park it in FAULT.
module robo_mission_sequencer #(
  parameter int ROWS       = 9,
  parameter int COLS       = 10,
  parameter int BIN_CAP    = 4,
  parameter int UNLOAD_CYC = 8
) (
  input logic                      clock,
  input logic                      reset,
  robo_mission_sequencer_if.slave  bus
);
  localparam int UW = $clog2(UNLOAD_CYC) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_UNLOAD, S_DONE, S_FAULT} state_t;

  state_t          state, nxt_state;
  logic [3:0]      row_q, col_q, items_q;
  logic [1:0]      dir_q;
  logic [7:0]      moves_q, max_q;
  logic [UW-1:0]   ucnt;
  logic            en_q, unl_q, done_q, fault_q, perr_q;

  logic            oob, mv;
  logic [3:0]      nrow, ncol, nitems;
  logic [1:0]      ndir;
  logic [7:0]      nmoves;

  // Advance wins over turn; a blocked advance leaves the pose untouched.
  always_comb begin
    nrow = row_q;
    ncol = col_q;
    ndir = dir_q;
    oob  = 1'b0;
    if (bus.advance) begin
      case (dir_q)
        2'b00:   if (row_q == 4'd1)        oob = 1'b1; else nrow = row_q - 4'd1;
        2'b01:   if (row_q == 4'(ROWS))    oob = 1'b1; else nrow = row_q + 4'd1;
        2'b10:   if (col_q == 4'(COLS))    oob = 1'b1; else ncol = col_q + 4'd1;
        default: if (col_q == 4'd1)        oob = 1'b1; else ncol = col_q - 4'd1;
      endcase
    end else if (bus.turn) begin
      case (dir_q)
        2'b00:   ndir = 2'b11;
        2'b11:   ndir = 2'b01;
        2'b01:   ndir = 2'b10;
        default: ndir = 2'b00;
      endcase
    end
    mv     = (bus.advance | bus.turn) & ~oob;
    nmoves = moves_q + {7'd0, mv};
    nitems = (bus.collect && items_q != 4'(BIN_CAP)) ? items_q + 4'd1 : items_q;

    nxt_state = state;
    case (state)
      S_IDLE, S_DONE, S_FAULT:
        if (bus.start) nxt_state = (bus.max_moves == 8'd0) ? S_DONE : S_RUN;
      S_RUN:
        if (oob)                          nxt_state = S_FAULT;
        else if (mv && nmoves == max_q)   nxt_state = S_DONE;
        else if (nitems == 4'(BIN_CAP))   nxt_state = S_UNLOAD;
      S_UNLOAD:
        if (ucnt == UW'(UNLOAD_CYC - 1))  nxt_state = S_RUN;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      row_q   <= 4'd1;
      col_q   <= 4'd1;
      dir_q   <= 2'b00;
      moves_q <= 8'd0;
      items_q <= 4'd0;
      max_q   <= 8'd0;
      ucnt    <= '0;
      en_q    <= 1'b0;
      unl_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      en_q    <= (nxt_state == S_RUN);
      unl_q   <= (nxt_state == S_UNLOAD);
      done_q  <= (nxt_state == S_DONE);
      fault_q <= (nxt_state == S_FAULT);
      case (state)
        S_IDLE, S_DONE, S_FAULT:
          if (bus.start) begin
            max_q   <= bus.max_moves;
            row_q   <= bus.start_row;
            col_q   <= bus.start_col;
            dir_q   <= bus.start_dir;
            moves_q <= 8'd0;
            items_q <= 4'd0;
            perr_q  <= 1'b0;
          end
        S_RUN: begin
          row_q   <= nrow;
          col_q   <= ncol;
          dir_q   <= ndir;
          moves_q <= nmoves;
          items_q <= nitems;
          ucnt    <= '0;
          if (bus.advance && bus.turn) perr_q <= 1'b1;
        end
        S_UNLOAD:
          if (nxt_state == S_RUN) begin
            items_q <= 4'd0;
            ucnt    <= '0;
          end else begin
            ucnt <= ucnt + UW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.robo_enable = en_q;
  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.dir         = dir_q;
  assign bus.moves       = moves_q;
  assign bus.items       = items_q;
  assign bus.unloading   = unl_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.proto_err   = perr_q;
endmodule
